// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter sharing one memory port, one access at a time.
// Optional MEM_ARBITER_RR_EN: round-robin tie-break instead of fixed data priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    typedef enum logic [2:0] {StIdle, StBusyI, StBusyD, StDoneI, StDoneD} state_t;

    state_t state;
    logic   grant_any;
    logic   grant_d;

`ifdef MEM_ARBITER_RR_EN
    logic last_d;  // last grant went to data; reset = fetch so data wins the first tie

    always_comb begin
        grant_any = i_req | d_req;
        grant_d   = d_req & (~i_req | ~last_d);
    end
`else
    always_comb begin
        grant_any = i_req | d_req;
        grant_d   = d_req;
    end
`endif

    // Captured address/data/direction live directly in the registered mem_* outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                StIdle: begin
                    if (grant_any) begin
                        mem_en <= 1'b1;
`ifdef MEM_ARBITER_RR_EN
                        last_d <= grant_d;
`endif
                        if (grant_d) begin
                            state     <= StBusyD;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wr    <= d_wr;
                        end else begin
                            state     <= StBusyI;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_wr    <= 1'b0;
                        end
                    end
                end
                StBusyI: begin
                    if (mem_done) begin
                        state   <= StDoneI;
                        mem_en  <= 1'b0;
                        i_ack   <= 1'b1;
                        i_rdata <= mem_rdata;
                    end
                end
                StBusyD: begin
                    if (mem_done) begin
                        state   <= StDoneD;
                        mem_en  <= 1'b0;
                        mem_wr  <= 1'b0;
                        d_ack   <= 1'b1;
                        d_rdata <= mem_wr ? '0 : mem_rdata;
                    end
                end
                StDoneI, StDoneD: state <= StIdle;
                default:          state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 16, data width of both requesters and the memory port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch request; held high until i_ack.
REQ-006 i_addr  input  ADDR_W  fetch address; stable while i_req high.
REQ-007 i_ack  output  1  one-cycle completion pulse for fetch.
REQ-008 i_rdata  output  DATA_W  fetched word; valid when i_ack high.
REQ-009 d_req  input  1  data request; held high until d_ack.
REQ-010 d_wr  input  1  1 = write, 0 = read; stable while d_req high.
REQ-011 d_addr  input  ADDR_W  data address; stable while d_req high.
REQ-012 d_wdata  input  DATA_W  write data; stable while d_req high.
REQ-013 d_ack  output  1  one-cycle completion pulse for data access.
REQ-014 d_rdata  output  DATA_W  read word; valid when d_ack high.
REQ-015 mem_en  output  1  memory access active; held high for whole access.
REQ-016 mem_wr  output  1  memory write strobe; qualified by mem_en.
REQ-017 mem_addr  output  ADDR_W  memory address, held stable while mem_en high.
REQ-018 mem_wdata  output  DATA_W  memory write data, held stable while mem_en high.
REQ-019 mem_rdata  input  DATA_W  memory read data; valid with mem_done.
REQ-020 mem_done  input  1  memory completion pulse; any latency of 1 or more cycles after mem_en rises.

Function
REQ-021 FSM states SHALL be IDLE, BUSY_I, BUSY_D, DONE_I and DONE_D.
REQ-022 Grant rule: IDLE evaluates requests; one pending SHALL grant it; both pending SHALL grant data (d_req) by default.
REQ-023 On grant, next state SHALL be BUSY_I or BUSY_D, capturing address, write data and d_wr into registers.
REQ-024 In BUSY_x: mem_en=1, mem_addr/mem_wdata/mem_wr from captured registers, mem_wr=0 for fetch.
REQ-025 In BUSY_x with mem_done=1, next state SHALL be DONE_x and mem_rdata SHALL be registered.
REQ-026 In DONE_x: mem_en=0, x_ack=1 for exactly one cycle, x_rdata = registered word (d_rdata=0 for writes); next state IDLE.
REQ-027 Minimum latency from i_req/d_req high in IDLE to ack: 2 cycles + memory latency; back-to-back accesses separated by at least one IDLE cycle.
REQ-028 mem_done outside BUSY_x SHALL be ignored.
REQ-029 Requester deasserting req mid-access SHALL NOT abort the access; the ack still pulses.
REQ-030 i_ack and d_ack SHALL never be high in the same cycle; at most one memory access outstanding.
REQ-031 i_rdata/d_rdata SHALL hold their last value outside ack cycles.

Reset
REQ-032 rst high SHALL force state IDLE and all outputs to 0 immediately, independent of clk.
REQ-033 Reset mid-access SHALL drop mem_en asynchronously, discard the access and issue no ack; first grant possible in the first edge after rst falls.

Configuration
REQ-034 Macro MEM_ARBITER_RR_EN defined: simultaneous requests SHALL be granted round-robin via a last-granted flag (reset value = fetch, so data wins first tie); flag updates on every grant.
REQ-035 MEM_ARBITER_RR_EN undefined: fixed data priority per REQ-022, no last-granted flag.

Verification
REQ-036 i_req, i_addr=0x0010, mem_done 3 cycles after mem_en, mem_rdata=0xA5A5 -> mem_addr=0x0010, mem_wr=0, i_ack one cycle with i_rdata=0xA5A5.
REQ-037 d_req, d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> mem_wr=1 with those values held until mem_done, d_ack pulse, d_rdata=0x0000, i_ack stays 0.
REQ-038 i_req and d_req raised same cycle, both held -> data served first, then fetch (fixed); with MEM_ARBITER_RR_EN three tied rounds -> order D, I, D.
REQ-039 rst pulsed during BUSY_D -> mem_en=0 same cycle, no d_ack, next request granted normally.
REQ-040 Spurious mem_done in IDLE with no requests -> no ack, state stays IDLE; d_req dropped mid-access -> d_ack still pulses once.
